// File: rtl/adc_volt_bcd.sv
// rtl/adc_volt_bcd.sv - XADC sample averaging, millivolt scaling and packed BCD conversion
module adc_volt_bcd #(
    parameter int AVG_LOG2 = 2,
    parameter int SCALE    = 333
) (
    input  logic        clk,
    input  logic        RESET_N,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic [15:0] bcd_out,
    output logic [13:0] mv_out,
    output logic        bcd_valid,
    output logic        busy,
    output logic        dropped
);

    localparam int AW = 12 + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {
        S_ACCUM,
        S_SCALE,
        S_CONVERT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [11:0]   code;
    logic          unused_lsb;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_sum;
    logic [CW-1:0] cnt;
    logic [3:0]    step;
    logic [11:0]   mul_a;
    logic [25:0]   mul_b;
    logic [25:0]   prod;
    logic [25:0]   prod_nxt;
    logic [13:0]   mv;
    logic [15:0]   dd_bcd;
    logic [15:0]   dd_adj;
    logic [13:0]   dd_bin;
    logic          accept;
    logic          win_last;

    assign code       = sample_in[15:4];
    assign unused_lsb = ^sample_in[3:0];
    assign accept     = (state == S_ACCUM) && sample_valid;
    assign win_last   = (cnt == CNT_LAST);
    assign acc_sum    = acc + AW'(code);
    assign prod_nxt   = mul_a[0] ? (prod + mul_b) : prod;
    assign busy       = (state != S_ACCUM);

    // Double-dabble correction: any digit >= 5 would overflow when doubled.
    always_comb begin
        dd_adj = dd_bcd;
        for (int i = 0; i < 4; i++) begin
            if (dd_bcd[4*i +: 4] >= 4'd5) begin
                dd_adj[4*i +: 4] = dd_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_ACCUM:   if (accept && win_last) state_nxt = S_SCALE;
            S_SCALE:   if (step == 4'd11) state_nxt = S_CONVERT;
            S_CONVERT: if (step == 4'd13) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_ACCUM;
            default:   state_nxt = S_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            acc       <= '0;
            cnt       <= '0;
            step      <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            prod      <= '0;
            mv        <= '0;
            dd_bcd    <= '0;
            dd_bin    <= '0;
            bcd_out   <= '0;
            mv_out    <= '0;
            bcd_valid <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            dropped   <= sample_valid && (state != S_ACCUM);
            case (state)
                S_ACCUM: begin
                    if (accept) begin
                        if (win_last) begin
                            acc   <= '0;
                            cnt   <= '0;
                            mul_a <= acc_sum[AW-1:AVG_LOG2];
                            mul_b <= 26'(SCALE);
                            prod  <= '0;
                            step  <= '0;
                        end else begin
                            acc <= acc_sum;
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_SCALE: begin
                    prod  <= prod_nxt;
                    mul_a <= mul_a >> 1;
                    mul_b <= mul_b << 1;
                    if (step == 4'd11) begin
                        mv     <= prod_nxt[25:12];
                        dd_bin <= prod_nxt[25:12];
                        dd_bcd <= '0;
                        step   <= '0;
                    end else begin
                        step <= step + 4'd1;
                    end
                end
                S_CONVERT: begin
                    {dd_bcd, dd_bin} <= {dd_adj[14:0], dd_bin, 1'b0};
                    step <= (step == 4'd13) ? 4'd0 : step + 4'd1;
                end
                S_DONE: begin
                    bcd_out   <= dd_bcd;
                    mv_out    <= mv;
                    bcd_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_volt_bcd.sv
// tb/tb_adc_volt_bcd.sv - randomized and directed checks of adc_volt_bcd against an arithmetic model
module tb_adc_volt_bcd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sample_in = '0;
    logic        sample_valid = 1'b0;

    always #5 clk = ~clk;

    logic [15:0] bcd [3];
    logic [13:0] mv  [3];
    logic        vld [3];
    logic        bsy [3];
    logic        drp [3];

    adc_volt_bcd #(.AVG_LOG2(0), .SCALE(333)) u_a0s333 (
        .clk(clk), .RESET_N(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
        .bcd_out(bcd[0]), .mv_out(mv[0]), .bcd_valid(vld[0]), .busy(bsy[0]), .dropped(drp[0]));
    adc_volt_bcd #(.AVG_LOG2(2), .SCALE(333)) u_a2s333 (
        .clk(clk), .RESET_N(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
        .bcd_out(bcd[1]), .mv_out(mv[1]), .bcd_valid(vld[1]), .busy(bsy[1]), .dropped(drp[1]));
    adc_volt_bcd #(.AVG_LOG2(0), .SCALE(9999)) u_a0s9999 (
        .clk(clk), .RESET_N(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
        .bcd_out(bcd[2]), .mv_out(mv[2]), .bcd_valid(vld[2]), .busy(bsy[2]), .dropped(drp[2]));

    int av_k [3] = '{0, 2, 0};
    int sc_k [3] = '{333, 333, 9999};

    int vectors = 0;
    int errors  = 0;

    // Reference: window sums, a due-edge for each pending result, and the edge
    // from which the block accepts samples again.
    int          n = 0;
    int          m_sum  [3];
    int          m_cnt  [3];
    int          free_at[3];
    int          due    [3];
    int          due_mv [3];
    int          e_mv   [3];
    logic [15:0] e_bcd  [3];
    logic        e_vld  [3];
    logic        e_bsy  [3];
    logic        e_drp  [3];

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_sum[k] = 0; m_cnt[k] = 0; free_at[k] = 0; due[k] = -1; due_mv[k] = 0;
            e_mv[k] = 0; e_bcd[k] = '0; e_vld[k] = 1'b0; e_bsy[k] = 1'b0; e_drp[k] = 1'b0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            n++;
            for (int k = 0; k < 3; k++) begin
                e_vld[k] = 1'b0;
                e_drp[k] = 1'b0;
                if (due[k] == n) begin
                    e_mv[k]  = due_mv[k];
                    e_bcd[k] = to_bcd(due_mv[k]);
                    e_vld[k] = 1'b1;
                    due[k]   = -1;
                end
                if (sample_valid) begin
                    if (n >= free_at[k]) begin
                        m_sum[k] += int'(sample_in[15:4]);
                        m_cnt[k]++;
                        if (m_cnt[k] == (1 << av_k[k])) begin
                            due_mv[k]  = ((m_sum[k] >> av_k[k]) * sc_k[k]) >> 12;
                            due[k]     = n + 27;
                            free_at[k] = n + 28;
                            m_sum[k]   = 0;
                            m_cnt[k]   = 0;
                        end
                    end else begin
                        e_drp[k] = 1'b1;
                    end
                end
                e_bsy[k] = (n < free_at[k] - 1);
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({bcd[k], mv[k], vld[k], bsy[k], drp[k]} !==
                {e_bcd[k], 14'(e_mv[k]), e_vld[k], e_bsy[k], e_drp[k]}) begin
                errors++;
                $display("FAIL model dut%0d t=%0t: got bcd=%h mv=%0d v=%b busy=%b drop=%b, want bcd=%h mv=%0d v=%b busy=%b drop=%b",
                         k, $time, bcd[k], mv[k], vld[k], bsy[k], drp[k],
                         e_bcd[k], e_mv[k], e_vld[k], e_bsy[k], e_drp[k]);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    int          st_at [$];
    logic [15:0] st_smp[$];
    int          rst_at = -1;
    int          v_at  [$];
    int          v_bcd [$];
    int          v_mv  [$];
    int          drops;

    // Cycle i of a play drives edge i; results are observed at the following negedge.
    task automatic play(input int k, input int ncyc);
        v_at.delete(); v_bcd.delete(); v_mv.delete();
        drops = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (st_at.size() > 0 && st_at[0] == i) begin
                sample_valid = 1'b1;
                sample_in    = st_smp[0];
                void'(st_at.pop_front());
                void'(st_smp.pop_front());
            end else begin
                sample_valid = 1'b0;
                sample_in    = 16'($urandom);
            end
            if (i == rst_at) begin
                #1 rst_n = 1'b0;
            end else if (rst_at >= 0 && i == rst_at + 2) begin
                #1 rst_n = 1'b1;
            end
            @(negedge clk);
            if (vld[k]) begin
                v_at.push_back(i);
                v_bcd.push_back(int'(bcd[k]));
                v_mv.push_back(int'(mv[k]));
            end
            if (drp[k]) drops++;
        end
        sample_valid = 1'b0;
        rst_at = -1;
    endtask

    task automatic reset_all();
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int rhold;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        check("reset_bcd", int'(bcd[0]), 0);
        check("reset_mv", int'(mv[0]), 0);
        check("reset_busy", int'(bsy[1]), 0);
        check("reset_valid", int'(vld[2]), 0);

        st_at = '{0}; st_smp = '{16'hE3E0};
        play(0, 40);
        check("single_count", v_at.size(), 1);
        check("single_latency", v_at.size() > 0 ? v_at[0] : -1, 27);
        check("single_bcd", v_bcd.size() > 0 ? v_bcd[0] : -1, 16'h0296);
        check("single_mv", v_mv.size() > 0 ? v_mv[0] : -1, 296);

        st_at = '{0, 40}; st_smp = '{16'hFFF0, 16'h0000};
        play(0, 80);
        check("pair_count", v_at.size(), 2);
        check("pair_full_bcd", v_bcd.size() > 0 ? v_bcd[0] : -1, 16'h0332);
        check("pair_zero_bcd", v_bcd.size() > 1 ? v_bcd[1] : -1, 16'h0000);
        check("pair_zero_at", v_at.size() > 1 ? v_at[1] : -1, 67);

        st_at = '{0}; st_smp = '{16'hFFF0};
        play(2, 40);
        check("maxscale_mv", v_mv.size() > 0 ? v_mv[0] : -1, 9996);
        check("maxscale_bcd", v_bcd.size() > 0 ? v_bcd[0] : -1, 16'h9996);

        reset_all();
        st_at = '{0, 30, 60, 90}; st_smp = '{16'h8000, 16'h8000, 16'h8000, 16'h8030};
        play(1, 140);
        check("avg_count", v_at.size(), 1);
        check("avg_latency", v_at.size() > 0 ? v_at[0] : -1, 117);
        check("avg_bcd", v_bcd.size() > 0 ? v_bcd[0] : -1, 16'h0166);

        st_at = '{0, 5, 27, 28}; st_smp = '{16'hE3E0, 16'h1230, 16'h4560, 16'hFFF0};
        play(0, 60);
        check("drop_pulses", drops, 2);
        check("drop_count", v_at.size(), 2);
        check("drop_first_bcd", v_bcd.size() > 0 ? v_bcd[0] : -1, 16'h0296);
        check("drop_next_at", v_at.size() > 1 ? v_at[1] : -1, 55);
        check("drop_next_bcd", v_bcd.size() > 1 ? v_bcd[1] : -1, 16'h0332);

        st_at = '{0}; st_smp = '{16'hE3E0}; rst_at = 15;
        play(0, 45);
        check("rst_no_valid", v_at.size(), 0);
        check("rst_bcd", int'(bcd[0]), 0);
        check("rst_mv", int'(mv[0]), 0);
        st_at = '{0}; st_smp = '{16'hFFF0};
        play(0, 35);
        check("rst_fresh_at", v_at.size() > 0 ? v_at[0] : -1, 27);
        check("rst_fresh_bcd", v_bcd.size() > 0 ? v_bcd[0] : -1, 16'h0332);

        rhold = 0;
        for (int i = 0; i < 4000; i++) begin
            sample_valid = ($urandom_range(0, 7) == 0);
            sample_in    = 16'($urandom);
            if (rhold > 0) begin
                rhold--;
                if (rhold == 0) begin
                    #1 rst_n = 1'b1;
                end
            end else if ($urandom_range(0, 599) == 0) begin
                #1 rst_n = 1'b0;
                rhold = 2;
            end
            @(negedge clk);
        end
        sample_valid = 1'b0;
        #1 rst_n = 1'b1;
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/adc_volt_bcd.md
# adc_volt_bcd

Sequential conversion stage between the XADC auxiliary-channel result and the four-digit seven-segment driver. It takes the 16-bit left-justified XADC sample, optionally averages a power-of-two window of samples, and scales the 12-bit code to millivolts with a shift-add multiplier. It then converts the result to four packed BCD digits with an iterative double-dabble. This replaces a wide combinational divide chain with a small multi-cycle datapath whose `bcd_out` feeds the display's `data_in` directly.

## Interface
- `AVG_LOG2`, 2: log2 of the averaging window. Legal values are 0..4. A value of 0 means no averaging.
- `SCALE`, 333: full-scale numerator in mV. The output is `mv = (code * SCALE) >> 12`. Legal values are 1..9999.
- `clk` in 1: single clock. All state changes on the rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `sample_in` in 16: XADC result, MSB-justified. `code = sample_in[15:4]`.
- `sample_valid` in 1: one-cycle strobe qualifying `sample_in`.
- `bcd_out` out 16: `{thousands, hundreds, tens, units}` in packed BCD. Held until the next result.
- `mv_out` out 14: binary millivolt value matching `bcd_out`.
- `bcd_valid` out 1: one-cycle pulse when `bcd_out`/`mv_out` update.
- `busy` out 1: high while scaling/converting. Samples offered while busy is high are dropped.
- `dropped` out 1: one-cycle pulse for each `sample_valid` arriving while `busy` is high.

## Operation
- States: `ACCUM`, `SCALE`, `CONVERT`, `DONE`. `busy = (state != ACCUM)`.
- `ACCUM` state:
  - On `sample_valid`, add `code` to `acc` (width 12+AVG_LOG2) and increment `cnt`.
  - When the accepted sample is number 2^AVG_LOG2 of the window, latch `avg = (acc + code) >> AVG_LOG2` (truncating), clear `acc`/`cnt`, and go to `SCALE`.
- `SCALE` state: 12 shift-add steps, one bit of `avg` per cycle, LSB first, into a 26-bit product. After the 12th step, `mv = product[25:12]` (truncate, no rounding), then go to `CONVERT`.
  - Width rule: `mv <= floor(4095*SCALE/4096) < SCALE <= 9999`, so `mv` always fits 14 bits and 4 BCD digits. No saturation logic is required.
- `CONVERT` state: double-dabble over 14 iterations, one per cycle. Each iteration adds 3 to any BCD nibble >= 5, then shifts left one bit, MSB of `mv` first. Go to `DONE`.
- `DONE` state: load `bcd_out` and `mv_out`, pulse `bcd_valid`, return to `ACCUM`.
- Dropping: any `sample_valid` seen in `SCALE`, `CONVERT` or `DONE` is ignored for the datapath and pulses `dropped` on the following cycle. The window count is not affected.
- A `sample_valid` that coincides with the `DONE`→`ACCUM` edge is dropped.

## Timing
- Let edge E sample the last `sample_valid` of a window.
  - `busy` goes high after E.
  - Edges E+1..E+12 perform the multiply steps.
  - Edges E+13..E+26 perform the double-dabble shifts.
  - Edge E+27 loads the outputs and asserts `bcd_valid` and `state=ACCUM`.
  - `bcd_valid` and `busy` are low after E+28.
- Latency is 27 cycles from the last accepted sample to `bcd_valid` high. Minimum spacing between accepted windows is 28 cycles.
- Throughput without drops requires `sample_valid` spacing >= 28 cycles. At the XADC sequencer rate this always holds.
- `dropped` is registered and appears 1 cycle after the offending strobe.
- Reset values: `bcd_out=16'h0000`, `mv_out=0`, `bcd_valid=0`, `busy=0`, `dropped=0`, `state=ACCUM`, `acc=0`, `cnt=0`.
- Reset asserted mid-operation (any state) immediately clears all state. The partial result is discarded and no `bcd_valid` is produced. After release, the next full window is required.
- Outputs change only at edge E+27 of a completed window. They are otherwise stable.

## Test plan
- AVG_LOG2=0, SCALE=333, `sample_in=16'hE3E0` one strobe:
  - `bcd_valid` exactly 27 cycles later.
  - `mv_out=296`, `bcd_out=16'h0296`.
- AVG_LOG2=0: `sample_in=16'hFFF0` gives `bcd_out=16'h0332`. `sample_in=16'h0000` gives `bcd_out=16'h0000`. Both windows spaced 40 cycles apart.
- AVG_LOG2=2, SCALE=333, four strobes with codes 0x800, 0x800, 0x800, 0x803:
  - Average is 2048, giving `bcd_out=16'h0166`.
  - Exactly one `bcd_valid`, 27 cycles after the 4th strobe.
- AVG_LOG2=0, SCALE=9999, `sample_in=16'hFFF0`: `mv_out=9996`, `bcd_out=16'h9996`. Confirms max-width path.
- Strobe at E+5 and E+27 during a conversion:
  - Two `dropped` pulses.
  - Result equals the first sample's value.
  - The next strobe at E+28 is accepted, with `bcd_valid` at E+55.
- Assert `RESET_N` low at E+15 for 2 cycles:
  - All outputs return to reset values and no `bcd_valid` appears.
  - A fresh strobe after release produces the correct result 27 cycles later.
